// File: rtl/vga_timing.sv
// vga_timing -- parametrised raster timing generator.
//
// Walks a (h_pos, v_pos) raster of H_TOTAL x V_TOTAL positions, advancing one
// position per clk edge with ce=1, and decodes sync, data-enable, line/frame
// strobes, a frame counter and an optional colour-bar test pattern. Every
// output is registered from the *next* position so it lines up with the
// h_pos/v_pos presented in the same cycle.
//
// Optional feature macro: VGA_TIMING_PATTERN_EN -- when defined, rgb carries
// 8 vertical colour bars; otherwise rgb is tied to 0 and no pattern logic exists.
//
// Ports:
//   clk          system clock (single domain)
//   reset        asynchronous, active-low
//   ce           pixel enable; position advances only when high
//   hs, vs       horizontal / vertical sync (asserted level HS_POL / VS_POL)
//   de           active-video flag
//   h_pos, v_pos current column / line
//   line_start   one-clk pulse when h_pos becomes 0
//   frame_start  one-clk pulse when position becomes (0,0)
//   frame        frame counter, wraps modulo 2^FRAME_W
//   rgb          {r,g,b} test pattern, CBITS per channel
module vga_timing #(
   parameter int H_ACT   = 640,
   parameter int H_FP    = 16,
   parameter int H_SYNC  = 96,
   parameter int H_BP    = 48,
   parameter int V_ACT   = 480,
   parameter int V_FP    = 10,
   parameter int V_SYNC  = 2,
   parameter int V_BP    = 33,
   parameter bit HS_POL  = 1'b0,
   parameter bit VS_POL  = 1'b0,
   parameter int CW      = 11,
   parameter int FRAME_W = 8,
   parameter int CBITS   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ce,
   output logic                 hs,
   output logic                 vs,
   output logic                 de,
   output logic [CW-1:0]        h_pos,
   output logic [CW-1:0]        v_pos,
   output logic                 line_start,
   output logic                 frame_start,
   output logic [FRAME_W-1:0]   frame,
   output logic [3*CBITS-1:0]   rgb
);

   localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT_C = CW'(H_ACT);
   localparam logic [CW-1:0] V_ACT_C = CW'(V_ACT);
   localparam logic [CW-1:0] HS_BEG  = CW'(H_ACT + H_FP);
   localparam logic [CW-1:0] HS_END  = CW'(H_ACT + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG  = CW'(V_ACT + V_FP);
   localparam logic [CW-1:0] VS_END  = CW'(V_ACT + V_FP + V_SYNC);

   logic          h_wrap, v_wrap;
   logic [CW-1:0] h_nxt, v_nxt;
   logic          de_nxt, hs_on, vs_on;

   // Next position and its decode; only committed on ce.
   always_comb begin
      h_wrap = (h_pos == H_LAST);
      v_wrap = (v_pos == V_LAST);
      h_nxt  = h_wrap ? '0 : h_pos + 1'b1;
      v_nxt  = v_pos;
      if (h_wrap)
         v_nxt = v_wrap ? '0 : v_pos + 1'b1;
      de_nxt = (h_nxt < H_ACT_C) && (v_nxt < V_ACT_C);
      hs_on  = (h_nxt >= HS_BEG) && (h_nxt < HS_END);
      vs_on  = (v_nxt >= VS_BEG) && (v_nxt < VS_END);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_pos       <= H_LAST;
         v_pos       <= V_LAST;
         de          <= 1'b0;
         hs          <= ~HS_POL;
         vs          <= ~VS_POL;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame       <= '1;
      end else begin
         // Strobes are qualified by ce so they last one clk, not one pixel.
         line_start  <= ce && h_wrap;
         frame_start <= ce && h_wrap && v_wrap;
         if (ce) begin
            h_pos <= h_nxt;
            v_pos <= v_nxt;
            de    <= de_nxt;
            hs    <= hs_on ? HS_POL : ~HS_POL;
            vs    <= vs_on ? VS_POL : ~VS_POL;
            if (h_wrap && v_wrap)
               frame <= frame + 1'b1;
         end
      end
   end

`ifdef VGA_TIMING_PATTERN_EN
   // Bars are at least one pixel wide so tiny test rasters still get a pattern.
   localparam int BW = (H_ACT / 8 > 0) ? H_ACT / 8 : 1;
   localparam logic [CW-1:0] BW_LAST = CW'(BW - 1);

   logic [CW-1:0] bar_cnt, bar_cnt_nxt;
   logic [2:0]    bar_idx, bar_idx_nxt;
   logic [2:0]    code;

   always_comb begin
      bar_cnt_nxt = bar_cnt + 1'b1;
      bar_idx_nxt = bar_idx;
      if (h_wrap) begin
         bar_cnt_nxt = '0;
         bar_idx_nxt = '0;
      end else if (bar_cnt == BW_LAST) begin
         bar_cnt_nxt = '0;
         // Saturate: the last bar absorbs the H_ACT % 8 remainder.
         bar_idx_nxt = (bar_idx == 3'd7) ? 3'd7 : bar_idx + 3'd1;
      end
      code = 3'd7 - bar_idx_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bar_cnt <= '0;
         bar_idx <= '0;
         rgb     <= '0;
      end else if (ce) begin
         bar_cnt <= bar_cnt_nxt;
         bar_idx <= bar_idx_nxt;
         rgb     <= de_nxt ? {{CBITS{code[1]}}, {CBITS{code[2]}}, {CBITS{code[0]}}} : '0;
      end
   end
`else
   assign rgb = '0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
module tb_vga_timing;

`ifdef VGA_TIMING_PATTERN_EN
   localparam bit PAT = 1'b1;
`else
   localparam bit PAT = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT A: default 640x480 timing
   logic        rst_a, ce_a;
   logic        hs_a, vs_a, de_a, ls_a, fs_a;
   logic [10:0] h_a, v_a;
   logic [7:0]  fr_a;
   logic [11:0] rgb_a;

   // DUT B: tiny raster H 4/1/2/1 (8), V 3/1/1/1 (6), 2-bit frame counter
   logic        rst_b, ce_b;
   logic        hs_b, vs_b, de_b, ls_b, fs_b;
   logic [3:0]  h_b, v_b;
   logic [1:0]  fr_b;
   logic [11:0] rgb_b;

   vga_timing u_a (
      .clk(clk), .reset(rst_a), .ce(ce_a), .hs(hs_a), .vs(vs_a), .de(de_a),
      .h_pos(h_a), .v_pos(v_a), .line_start(ls_a), .frame_start(fs_a),
      .frame(fr_a), .rgb(rgb_a));

   vga_timing #(
      .H_ACT(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACT(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .CW(4), .FRAME_W(2)
   ) u_b (
      .clk(clk), .reset(rst_b), .ce(ce_b), .hs(hs_b), .vs(vs_b), .de(de_b),
      .h_pos(h_b), .v_pos(v_b), .line_start(ls_b), .frame_start(fs_b),
      .frame(fr_b), .rgb(rgb_b));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic       ce;
      logic [3:0] h, v;
      logic       hs, vs, de, ls, fs;
      logic [1:0] fr;
      logic [11:0] rgb;
   } vec_t;

   function automatic vec_t mk(input bit c, input int h, input int v, input bit hs,
                               input bit vs, input bit de, input bit ls, input bit fs,
                               input int fr, input int rgb);
      vec_t m;
      m.ce = c; m.h = 4'(h); m.v = 4'(v); m.hs = hs; m.vs = vs; m.de = de;
      m.ls = ls; m.fs = fs; m.fr = 2'(fr); m.rgb = 12'(rgb);
      return m;
   endfunction

   task automatic chk_reset_b(input string tag);
      chk({tag, "_h"},  h_b, 7);
      chk({tag, "_v"},  v_b, 5);
      chk({tag, "_de"}, de_b, 0);
      chk({tag, "_hs"}, hs_b, 1);
      chk({tag, "_vs"}, vs_b, 1);
      chk({tag, "_ls"}, ls_b, 0);
      chk({tag, "_fs"}, fs_b, 0);
      chk({tag, "_fr"}, fr_b, 3);
      chk({tag, "_rgb"}, rgb_b, 0);
   endtask

   vec_t tbl[15];

   initial begin
      int bad_pos, bad_hs, bad_de, bad_ls, bad_rgb, bad_vs, bad_per, bad_fr, vs_low;
      int nfs, last_fs;
      logic [11:0] er;

      // rows: ce, h, v, hs, vs, de, ls, fs, frame, rgb(pattern build)
      tbl[0]  = mk(1, 0, 0, 1, 1, 1, 1, 1, 0, 'hFFF);
      tbl[1]  = mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 'hFFF);
      tbl[2]  = mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 'hFFF);
      tbl[3]  = mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 'hFFF);
      tbl[4]  = mk(1, 1, 0, 1, 1, 1, 0, 0, 0, 'hFF0);
      tbl[5]  = mk(0, 1, 0, 1, 1, 1, 0, 0, 0, 'hFF0);
      tbl[6]  = mk(1, 2, 0, 1, 1, 1, 0, 0, 0, 'h0FF);
      tbl[7]  = mk(1, 3, 0, 1, 1, 1, 0, 0, 0, 'h0F0);
      tbl[8]  = mk(1, 4, 0, 1, 1, 0, 0, 0, 0, 'h000);
      tbl[9]  = mk(1, 5, 0, 0, 1, 0, 0, 0, 0, 'h000);
      tbl[10] = mk(0, 5, 0, 0, 1, 0, 0, 0, 0, 'h000);
      tbl[11] = mk(1, 6, 0, 0, 1, 0, 0, 0, 0, 'h000);
      tbl[12] = mk(1, 7, 0, 1, 1, 0, 0, 0, 0, 'h000);
      tbl[13] = mk(1, 0, 1, 1, 1, 1, 1, 0, 0, 'hFFF);
      tbl[14] = mk(1, 1, 1, 1, 1, 1, 0, 0, 0, 'hFF0);

      rst_a = 1'b0; rst_b = 1'b0; ce_a = 1'b0; ce_b = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("a_rst_h", h_a, 799);
      chk("a_rst_v", v_a, 524);
      chk("a_rst_de", de_a, 0);
      chk("a_rst_hs", hs_a, 1);
      chk("a_rst_vs", vs_a, 1);
      chk("a_rst_ls", ls_a, 0);
      chk("a_rst_fs", fs_a, 0);
      chk("a_rst_fr", fr_a, 8'hFF);
      chk("a_rst_rgb", rgb_a, 0);

      @(negedge clk);
      rst_a = 1'b1; rst_b = 1'b1; ce_a = 1'b1;
      #1;
      chk("a_pre_h", h_a, 799);
      chk("a_pre_v", v_a, 524);
      @(posedge clk); #1;
      chk("a_first_h", h_a, 0);
      chk("a_first_v", v_a, 0);
      chk("a_first_de", de_a, 1);
      chk("a_first_ls", ls_a, 1);
      chk("a_first_fs", fs_a, 1);
      chk("a_first_fr", fr_a, 0);
      chk("a_first_vs", vs_a, 1);

      // One full default line
      bad_pos = 0; bad_hs = 0; bad_de = 0; bad_ls = 0; bad_rgb = 0;
      for (int x = 0; x < 800; x++) begin
         if (h_a !== 11'(x) || v_a !== 11'd0) bad_pos++;
         if (hs_a !== !(x >= 656 && x < 752)) bad_hs++;
         if (de_a !== (x < 640)) bad_de++;
         if (ls_a !== (x == 0)) bad_ls++;
         if (x > 0 && fs_a !== 1'b0) bad_ls++;
         er = 12'hxxx;
         if (!PAT || x >= 640 || x == 639) er = 12'h000;
         else if (x < 80) er = 12'hFFF;
         else if (x == 80) er = 12'hFF0;
         if (!$isunknown(er) && rgb_a !== er) bad_rgb++;
         @(posedge clk); #1;
      end
      chk("a_line_pos", bad_pos, 0);
      chk("a_line_hs", bad_hs, 0);
      chk("a_line_de", bad_de, 0);
      chk("a_line_strobe", bad_ls, 0);
      chk("a_line_rgb", bad_rgb, 0);
      chk("a_wrap_h", h_a, 0);
      chk("a_wrap_v", v_a, 1);
      chk("a_wrap_ls", ls_a, 1);
      chk("a_wrap_fs", fs_a, 0);
      ce_a = 1'b0;

      // Tiny raster: still in reset state (ce_b was low)
      chk_reset_b("b_rst");
      for (int i = 0; i < 15; i++) begin
         ce_b = tbl[i].ce;
         @(posedge clk); #1;
         chk($sformatf("b_tbl%0d_h", i), h_b, tbl[i].h);
         chk($sformatf("b_tbl%0d_v", i), v_b, tbl[i].v);
         chk($sformatf("b_tbl%0d_hs", i), hs_b, tbl[i].hs);
         chk($sformatf("b_tbl%0d_vs", i), vs_b, tbl[i].vs);
         chk($sformatf("b_tbl%0d_de", i), de_b, tbl[i].de);
         chk($sformatf("b_tbl%0d_ls", i), ls_b, tbl[i].ls);
         chk($sformatf("b_tbl%0d_fs", i), fs_b, tbl[i].fs);
         chk($sformatf("b_tbl%0d_fr", i), fr_b, tbl[i].fr);
         chk($sformatf("b_tbl%0d_rgb", i), rgb_b, PAT ? tbl[i].rgb : 12'h000);
      end

      // Several frames with ce held high: vs window, frame period, frame wrap
      ce_b = 1'b1;
      bad_hs = 0; bad_vs = 0; bad_de = 0; bad_ls = 0; bad_per = 0; bad_fr = 0;
      vs_low = 0; nfs = 0; last_fs = 0;
      for (int c = 0; c < 600 && nfs < 4; c++) begin
         @(posedge clk); #1;
         if (hs_b !== !(h_b == 4'd5 || h_b == 4'd6)) bad_hs++;
         if (vs_b !== (v_b != 4'd4)) bad_vs++;
         if (de_b !== (h_b < 4'd4 && v_b < 4'd3)) bad_de++;
         if (ls_b !== (h_b == 4'd0)) bad_ls++;
         if (fs_b !== (h_b == 4'd0 && v_b == 4'd0)) bad_ls++;
         if (!vs_b) vs_low++;
         if (fs_b) begin
            nfs++;
            if (fr_b !== 2'(nfs)) bad_fr++;
            if (nfs > 1 && c - last_fs != 48) bad_per++;
            last_fs = c;
         end
      end
      chk("b_frames_seen", nfs, 4);
      chk("b_sweep_hs", bad_hs, 0);
      chk("b_sweep_vs", bad_vs, 0);
      chk("b_sweep_de", bad_de, 0);
      chk("b_sweep_strobes", bad_ls, 0);
      chk("b_sweep_period", bad_per, 0);
      chk("b_sweep_frame", bad_fr, 0);
      chk("b_vs_seen", vs_low > 0, 1);

      // Mid-frame asynchronous reset, then restart
      repeat (17) @(posedge clk);
      #1;
      chk("b_mid_h", h_b, 1);
      chk("b_mid_v", v_b, 2);
      chk("b_mid_de", de_b, 1);
      #2 rst_b = 1'b0;
      #1 chk_reset_b("b_async");
      @(negedge clk);
      rst_b = 1'b1;
      @(posedge clk); #1;
      chk("b_restart_h", h_b, 0);
      chk("b_restart_v", v_b, 0);
      chk("b_restart_de", de_b, 1);
      chk("b_restart_ls", ls_b, 1);
      chk("b_restart_fs", fs_b, 1);
      chk("b_restart_fr", fr_b, 0);
      chk("b_restart_rgb", rgb_b, PAT ? 12'hFFF : 12'h000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
